// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light sensor conditioning stage.
//   db_state_t   : debounce FSM state encoding (LOW, RISE_CHK, HIGH, FALL_CHK)
//   GLITCH_W     : width of the diagnostic glitch counter
//   GLITCH_MAX   : saturation value of the glitch counter
//   cnt_width()  : width of the per-channel confirm counter for a given DB_CYCLES
package tlc_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles) + 1;
    endfunction

endpackage

// File: rtl/tlc_db_chan.sv
// One sensor channel: input synchroniser, confirm-count debounce FSM,
// rise pulse, sticky request and abort flag.
//   ck, rst_n   : clock, asynchronous active-low reset (release already synchronised)
//   raw         : unsynchronised sensor level
//   ack         : controller acknowledge, clears held_req
//   level       : debounced level (registered)
//   rise_pulse  : one-cycle pulse on confirmed 0->1 (registered)
//   held_req    : sticky request, set by a confirmed rise, cleared by ack (registered)
//   abort       : high in the cycle a confirmation is being abandoned
//   state_dbg   : current FSM state
module tlc_db_chan
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic      ck,
    input  logic      rst_n,
    input  logic      raw,
    input  logic      ack,
    output logic      level,
    output logic      rise_pulse,
    output logic      held_req,
    output logic      abort,
    output db_state_t state_dbg
);

    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    db_state_t              state;
    logic [CW-1:0]          cnt;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Derived from registered state and the last synchroniser stage only,
    // so the top-level sum has no path back to raw_in.
    assign abort     = ((state == RISE_CHK) && !s) || ((state == FALL_CHK) && s);
    assign state_dbg = state;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOW;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            held_req   <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            if (ack && held_req) begin
                held_req <= 1'b0;
            end
            case (state)
                LOW: begin
                    if (s) begin
                        state <= RISE_CHK;
                        cnt   <= CW'(1);
                    end
                end
                RISE_CHK: begin
                    if (!s) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state      <= HIGH;
                        cnt        <= '0;
                        level      <= 1'b1;
                        rise_pulse <= 1'b1;
                        // Placed after the ack clear so a same-cycle rise wins.
                        held_req   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state <= FALL_CHK;
                        cnt   <= CW'(1);
                    end
                end
                FALL_CHK: begin
                    if (s) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tlc_sensor_cond.sv
// Input conditioning for the traffic-light controller: N_CH debounced
// sensor channels plus a saturating count of rejected glitches.
//   CK, RSTN    : clock, asynchronous active-low reset
//   raw_in      : unsynchronised sensor levels
//   ack         : per-channel acknowledge for held_req
//   level_out   : debounced levels (channel 0..2 -> controller inputs 200..202)
//   rise_pulse  : one-cycle pulses on confirmed rises
//   held_req    : sticky requests
//   glitch_cnt  : saturating count of aborted confirmations, all channels
//   state_dbg   : per-channel FSM state, channel i at [2i+1:2i]
module tlc_sensor_cond
    import tlc_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic                CK,
    input  logic                RSTN,
    input  logic [N_CH-1:0]     raw_in,
    input  logic [N_CH-1:0]     ack,
    output logic [N_CH-1:0]     level_out,
    output logic [N_CH-1:0]     rise_pulse,
    output logic [N_CH-1:0]     held_req,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic [2*N_CH-1:0]   state_dbg
);

    if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
        $error("tlc_sensor_cond: DB_CYCLES must be in 2..255");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("tlc_sensor_cond: SYNC_STAGES must be in 2..4");
    end

    localparam int ACC_W = GLITCH_W + $clog2(N_CH + 1);

    // Reset asserts immediately, releases after two clean edges.
    logic [1:0] rel;
    logic       rst_int_n;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            rel <= '0;
        end else begin
            rel <= {rel[0], 1'b1};
        end
    end

    assign rst_int_n = rel[1];

    logic [N_CH-1:0] abort_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        db_state_t st;
        tlc_db_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_chan (
            .ck         (CK),
            .rst_n      (rst_int_n),
            .raw        (raw_in[i]),
            .ack        (ack[i]),
            .level      (level_out[i]),
            .rise_pulse (rise_pulse[i]),
            .held_req   (held_req[i]),
            .abort      (abort_vec[i]),
            .state_dbg  (st)
        );
        assign state_dbg[2*i+1:2*i] = st;
    end

    logic [ACC_W-1:0]    sum;
    logic [GLITCH_W-1:0] glitch_next;

    always_comb begin
        sum = ACC_W'(glitch_cnt);
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + ACC_W'(abort_vec[i]);
        end
        glitch_next = (sum > ACC_W'(GLITCH_MAX)) ? GLITCH_MAX : sum[GLITCH_W-1:0];
    end

    always_ff @(posedge CK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            glitch_cnt <= '0;
        end else begin
            glitch_cnt <= glitch_next;
        end
    end

endmodule

// File: tb/tb_tlc_sensor_cond.sv
module tb_tlc_sensor_cond;

    localparam int N_CH = 3;
    localparam int W    = 32;

    logic              CK;
    logic              RSTN;
    logic [N_CH-1:0]   raw_in;
    logic [N_CH-1:0]   ack;
    logic [N_CH-1:0]   level_out;
    logic [N_CH-1:0]   rise_pulse;
    logic [N_CH-1:0]   held_req;
    logic [7:0]        glitch_cnt;
    logic [2*N_CH-1:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int g_exp   = 0;
    int hi_len;

    logic [W-1:0] exp_q[$];

    tlc_sensor_cond #(
        .N_CH        (N_CH),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4)
    ) dut (
        .CK         (CK),
        .RSTN       (RSTN),
        .raw_in     (raw_in),
        .ack        (ack),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .held_req   (held_req),
        .glitch_cnt (glitch_cnt),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial CK = 1'b0;
    always #5 CK = ~CK;

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CK);
            #1;
        end
    endtask

    task automatic exp_push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    // scoreboard: pop the oldest expectation and compare
    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] expv;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            end
        end
    endtask

    initial begin
        // reset with all sensors active
        RSTN   = 1'b0;
        raw_in = 3'b111;
        ack    = 3'b000;
        exp_push(0); exp_push(0); exp_push(0); exp_push(0); exp_push(0);
        tick(3);
        check("rst_level", level_out);
        check("rst_rise", rise_pulse);
        check("rst_held", held_req);
        check("rst_glitch", glitch_cnt);
        check("rst_state", state_dbg);

        // release: levels confirm 8 edges later
        RSTN = 1'b1;
        exp_push(3'b000); exp_push(3'b000);
        exp_push(3'b111); exp_push(3'b111); exp_push(3'b111);
        exp_push(3'b000);
        tick(7);
        check("rel_early_level", level_out);
        check("rel_early_rise", rise_pulse);
        tick(1);
        check("rel_level", level_out);
        check("rel_rise", rise_pulse);
        check("rel_held", held_req);
        tick(1);
        check("rel_rise_end", rise_pulse);

        ack = 3'b111;
        exp_push(3'b000);
        tick(1);
        ack = 3'b000;
        check("rel_ack_clear", held_req);

        // clean fall on all channels, no fall pulse
        raw_in = 3'b000;
        exp_push(3'b111); exp_push(3'b000); exp_push(3'b000); exp_push(0);
        tick(5);
        check("fall_early", level_out);
        tick(1);
        check("fall_level", level_out);
        check("fall_no_pulse", rise_pulse);
        check("fall_glitch", glitch_cnt);

        // clean rise on channel 0
        raw_in = 3'b001;
        exp_push(2'd1);
        exp_push(3'b000);
        exp_push(3'b001); exp_push(3'b001); exp_push(3'b001);
        exp_push(3'b000); exp_push(3'b001);
        exp_push(3'b000);
        tick(3);
        check("rise0_state", state_dbg[1:0]);
        tick(2);
        check("rise0_early", level_out);
        tick(1);
        check("rise0_level", level_out);
        check("rise0_pulse", rise_pulse);
        check("rise0_held", held_req);
        tick(1);
        check("rise0_pulse_end", rise_pulse);
        tick(2);
        check("rise0_held_hold", held_req);
        ack = 3'b001;
        tick(1);
        ack = 3'b000;
        check("rise0_ack", held_req);

        // 3-cycle glitch on channel 1
        raw_in = 3'b011;
        exp_push(0); exp_push(1); exp_push(3'b001);
        tick(3);
        raw_in = 3'b001;
        tick(2);
        check("glitch1_before", glitch_cnt);
        tick(1);
        g_exp = 1;
        check("glitch1_count", glitch_cnt);
        tick(3);
        check("glitch1_level", level_out);

        // channel 1 goes high, then low dips get rejected
        raw_in = 3'b011;
        exp_push(3'b001); exp_push(3'b011); exp_push(3'b010); exp_push(3'b010);
        exp_push(3'b000);
        tick(5);
        check("rise1_early", level_out);
        tick(1);
        check("rise1_level", level_out);
        check("rise1_pulse", rise_pulse);
        check("rise1_held", held_req);
        ack = 3'b010;
        tick(1);
        ack = 3'b000;
        check("rise1_ack", held_req);

        for (int d = 0; d < 2; d++) begin
            raw_in = 3'b001;
            g_exp  = g_exp + 1;
            exp_push(W'(g_exp));
            exp_push(3'b011);
            tick(3);
            raw_in = 3'b011;
            tick(3);
            check("dip_glitch", glitch_cnt);
            check("dip_level", level_out);
        end

        // ack in the same cycle as the rise on channel 2: set wins
        raw_in = 3'b111;
        exp_push(3'b100); exp_push(3'b100); exp_push(3'b111);
        exp_push(3'b100); exp_push(3'b000);
        exp_push(3'b000);
        tick(5);
        ack = 3'b100;
        tick(1);
        ack = 3'b000;
        check("same_rise", rise_pulse);
        check("same_held", held_req);
        check("same_level", level_out);
        tick(1);
        check("same_held_hold", held_req);
        check("same_rise_end", rise_pulse);
        ack = 3'b100;
        tick(1);
        ack = 3'b000;
        check("same_ack2", held_req);

        // saturation: dips on all three channels together
        for (int k = 0; k < 100; k++) begin
            raw_in = 3'b000;
            g_exp  = (g_exp + 3 > 255) ? 255 : g_exp + 3;
            exp_push(W'(g_exp));
            tick(3);
            raw_in = 3'b111;
            hi_len = $urandom_range(5, 7);
            tick(hi_len);
            check("sat_glitch", glitch_cnt);
        end
        exp_push(3'b111); exp_push(255);
        check("sat_level", level_out);
        check("sat_final", glitch_cnt);

        // reset during RISE_CHK with cnt=2
        raw_in = 3'b000;
        exp_push(3'b000); exp_push(255);
        tick(8);
        check("pre_rst_level", level_out);
        check("pre_rst_glitch", glitch_cnt);

        raw_in = 3'b001;
        exp_push(2'd1);
        tick(4);
        check("mid_state", state_dbg[1:0]);
        RSTN = 1'b0;
        #1;
        exp_push(0); exp_push(0); exp_push(0); exp_push(0); exp_push(0);
        check("mid_rst_level", level_out);
        check("mid_rst_rise", rise_pulse);
        check("mid_rst_held", held_req);
        check("mid_rst_glitch", glitch_cnt);
        check("mid_rst_state", state_dbg);
        tick(2);
        RSTN = 1'b1;
        exp_push(3'b000); exp_push(3'b000);
        exp_push(3'b001); exp_push(3'b001); exp_push(3'b001);
        tick(7);
        check("mid_rel_early_level", level_out);
        check("mid_rel_early_rise", rise_pulse);
        tick(1);
        check("mid_rel_level", level_out);
        check("mid_rel_rise", rise_pulse);
        check("mid_rel_held", held_req);

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL leftover_expect: observed %0d queued, expected 0", exp_q.size());
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
